multi_cycle_control_fsm: RTL and testbench

Main control state machine for the multicycle RV32I core. It sequences the shared datapath (PC, IR, A/B, MDR, ALUOut, single memory port) through fetch, decode, execute, memory and writeback steps. It stretches memory steps with a ready handshake and bounded timeout. It latches a halt on illegal opcodes or bus timeout.

---
 rtl/multi_cycle_control_fsm_pkg.sv | 98 +++++++++
 rtl/multi_cycle_control_fsm_if.sv | 40 ++++
 rtl/multi_cycle_control_fsm_mem_wait_timer.sv | 43 ++++
 rtl/multi_cycle_control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control path and its datapath:
// opcode constants, 6-bit state codes, datapath mux/ALU encodings and the
// DECODE-stage dispatch helper.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller state codes (visible on oState for debug)
    typedef enum logic [5:0] {
        S_FETCH    = 6'd0,
        S_DECODE   = 6'd1,
        S_MEMADDR  = 6'd2,
        S_MEMREAD  = 6'd3,
        S_MEMWB    = 6'd4,
        S_MEMWRITE = 6'd5,
        S_EXEC_R   = 6'd6,
        S_EXEC_I   = 6'd7,
        S_LUI      = 6'd8,
        S_ALUWB    = 6'd9,
        S_BRANCH   = 6'd10,
        S_JAL      = 6'd11,
        S_JALR     = 6'd12,
        S_ILLEGAL  = 6'd62,
        S_BUSERR   = 6'd63
    } state_t;

    // Next-PC source
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,   // ALU result (PC+4 in FETCH)
        PCSRC_ALUOUT = 2'd1,   // ALUOut (branch/JAL target computed in DECODE)
        PCSRC_JAL    = 2'd2,   // dedicated JAL address
        PCSRC_JALR   = 2'd3    // ALU result with bit 0 cleared
    } pcsrc_t;

    typedef enum logic [1:0] {
        SRCA_PC     = 2'd0,
        SRCA_A      = 2'd1,
        SRCA_PCBACK = 2'd2     // PC of the instruction currently in IR
    } alu_src_a_t;

    typedef enum logic [2:0] {
        SRCB_B    = 3'd0,
        SRCB_FOUR = 3'd1,
        SRCB_IMM  = 3'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'd0,
        ALUOP_BRANCH = 2'd1,
        ALUOP_FUNCT  = 2'd2,
        ALUOP_PASSB  = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'd0,
        M2R_MDR    = 2'd1,
        M2R_PC     = 2'd2     // link value (PC already advanced in FETCH)
    } mem_to_reg_t;

    // DECODE dispatch: first state of the execute sequence for an opcode.
    // AUIPC goes straight to write-back because DECODE already leaves
    // PCBack+imm in ALUOut.
    function automatic state_t decode_op(input logic [6:0] op);
        state_t s;
        case (op)
            OP_LOAD,
            OP_STORE:  s = S_MEMADDR;
            OP_RTYPE:  s = S_EXEC_R;
            OP_ITYPE:  s = S_EXEC_I;
            OP_BRANCH: s = S_BRANCH;
            OP_JAL:    s = S_JAL;
            OP_JALR:   s = S_JALR;
            OP_LUI:    s = S_LUI;
            OP_AUIPC:  s = S_ALUWB;
            default:   s = S_ILLEGAL;
        endcase
        return s;
    endfunction

    // States that hold the memory port and wait for iMemReady.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multi_cycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_fsm_if
// Bundle between the control FSM and the multicycle datapath.
//   iOp, iMemReady        : datapath/memory -> controller
//   o* control outputs    : controller -> datapath
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multi_cycle_control_fsm_if;
    logic [6:0] iOp;
    logic       iMemReady;
    logic       oIRWrite;
    logic       oPCWrite;
    logic       oPCWriteCond;
    logic [1:0] oPCSource;
    logic       oIorD;
    logic       oMemRead;
    logic       oMemWrite;
    logic [1:0] oMemtoReg;
    logic       oRegWrite;
    logic [1:0] oALUSrcA;
    logic [2:0] oALUSrcB;
    logic [1:0] oALUOp;
    logic [5:0] oState;
    logic       oHalt;
    logic       oBusErr;

    modport master (
        input  iOp, iMemReady,
        output oIRWrite, oPCWrite, oPCWriteCond, oPCSource, oIorD, oMemRead,
               oMemWrite, oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
               oState, oHalt, oBusErr
    );

    modport slave (
        output iOp, iMemReady,
        input  oIRWrite, oPCWrite, oPCWriteCond, oPCSource, oIorD, oMemRead,
               oMemWrite, oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
               oState, oHalt, oBusErr
    );
endinterface

// File: rtl/multi_cycle_control_fsm_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory step waits for ready and flags a
// timeout on the cycle whose count would reach WAIT_LIMIT.
// Ports:
//   iCLK    in  clock
//   iRST    in  asynchronous active-low reset
//   clr     in  clear count (not waiting, or memory ready this cycle)
//   en      in  a memory step is waiting this cycle (ready low)
//   timeout out this waiting cycle is the WAIT_LIMIT-th in a row
// CNT_W must satisfy 2**CNT_W > WAIT_LIMIT.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_reg + 1'b1;

    // Combinational so the FSM leaves on the very cycle the limit is hit;
    // a ready in that same cycle drops en and therefore wins.
    assign timeout = en && (cnt_inc == CNT_W'(WAIT_LIMIT));

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !timeout) begin
            cnt_reg <= cnt_inc;
        end
    end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_fsm
// Main control FSM of the multicycle RV32I core. Sequences the shared
// datapath through fetch / decode / execute / memory / write-back, stretches
// memory steps with iMemReady and a bounded wait, and parks in a halt state
// on an illegal opcode or a bus timeout (left only through reset).
// Ports:
//   iCLK  in  clock, rising edge
//   iRST  in  asynchronous active-low reset
//   bus   master modport: iOp, iMemReady in; datapath controls, oState,
//         oHalt, oBusErr out
// Controls are decoded combinationally from the current state; the write
// strobes are also forced low while reset is asserted.
// ---------------------------------------------------------------------------
module multi_cycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    multi_cycle_control_fsm_if.master   bus
);

    state_t      state_reg;
    logic        mem_waiting;
    logic        timeout;

    // Decoded controls before reset gating of the strobes
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        iord;
    pcsrc_t      pc_source;
    mem_to_reg_t mem_to_reg;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
    logic        halt;
    logic        bus_err;

    // -----------------------------------------------------------------
    // Memory wait timer: runs only while a memory step sees ready low;
    // any other cycle (including a ready) restarts it from zero.
    // -----------------------------------------------------------------
    assign mem_waiting = is_mem_wait_state(state_reg) && !bus.iMemReady;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .clr     (!mem_waiting),
        .en      (mem_waiting),
        .timeout (timeout)
    );

    // -----------------------------------------------------------------
    // State register and transitions
    // -----------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (bus.iMemReady)  state_reg <= S_DECODE;
                    else if (timeout)   state_reg <= S_BUSERR;
                end
                S_DECODE:   state_reg <= decode_op(bus.iOp);
                // Only loads and stores reach MEMADDR; IR still holds the op.
                S_MEMADDR:  state_reg <= (bus.iOp == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    if (bus.iMemReady)  state_reg <= S_MEMWB;
                    else if (timeout)   state_reg <= S_BUSERR;
                end
                S_MEMWRITE: begin
                    if (bus.iMemReady)  state_reg <= S_FETCH;
                    else if (timeout)   state_reg <= S_BUSERR;
                end
                S_EXEC_R,
                S_EXEC_I,
                S_LUI:      state_reg <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH,
                S_JAL,
                S_JALR:     state_reg <= S_FETCH;
                S_ILLEGAL,
                S_BUSERR:   state_reg <= state_reg;
                default:    state_reg <= S_ILLEGAL;
            endcase
        end
    end

    // -----------------------------------------------------------------
    // Control decode from the current state
    // -----------------------------------------------------------------
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        iord          = 1'b0;
        pc_source     = PCSRC_ALU;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        halt          = 1'b0;
        bus_err       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                iord     = 1'b0;
                mem_read = 1'b1;
                // IR load and PC+4 commit only on the completing cycle.
                if (bus.iMemReady) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALUOP_ADD;
                    pc_source = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                // Speculative PCBack+imm into ALUOut (branch/JAL target, AUIPC)
                alu_src_a = SRCA_PCBACK;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMADDR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            S_MEMWRITE: begin
                // Request held for the whole access until memory is ready.
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_B;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_LUI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_PASSB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_A;
                alu_src_b     = SRCB_B;
                alu_op        = ALUOP_BRANCH;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                pc_write   = 1'b1;
                pc_source  = PCSRC_ALUOUT;
            end
            S_JALR: begin
                // A was latched in DECODE, so overwriting rd this edge
                // cannot disturb the target computation.
                alu_src_a  = SRCA_A;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                pc_source  = PCSRC_JALR;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
            end
            S_ILLEGAL: begin
                halt = 1'b1;
            end
            S_BUSERR: begin
                halt    = 1'b1;
                bus_err = 1'b1;
            end
            default: begin
                halt = 1'b1;
            end
        endcase
    end

    // Strobes are qualified by reset so nothing commits while iRST is low,
    // even though FETCH is the reset state.
    assign bus.oIRWrite     = ir_write      & iRST;
    assign bus.oPCWrite     = pc_write      & iRST;
    assign bus.oPCWriteCond = pc_write_cond & iRST;
    assign bus.oRegWrite    = reg_write     & iRST;
    assign bus.oMemWrite    = mem_write     & iRST;
    assign bus.oMemRead     = mem_read;
    assign bus.oIorD        = iord;
    assign bus.oPCSource    = pc_source;
    assign bus.oMemtoReg    = mem_to_reg;
    assign bus.oALUSrcA     = alu_src_a;
    assign bus.oALUSrcB     = alu_src_b;
    assign bus.oALUOp       = alu_op;
    assign bus.oState       = state_reg;
    assign bus.oHalt        = halt;
    assign bus.oBusErr      = bus_err;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control_fsm
// Self-checking bench for the multicycle control FSM (WAIT_LIMIT = 4).
// Directed vector table, hand-written corner sequences (halt, timeout,
// reset during a store) and randomized instructions checked against a
// per-instruction cycle-sequence model.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control_fsm;

    localparam int LIMIT = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic iCLK = 1'b0;
    logic iRST;

    multi_cycle_control_fsm_if bus();

    multi_cycle_control_fsm #(
        .WAIT_LIMIT (LIMIT),
        .CNT_W      (8)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic [1:0] m2r;
        logic       regw;
        logic [1:0] srca;
        logic [2:0] srcb;
        logic [1:0] aluop;
        logic       halt;
        logic       buserr;
    } ctrl_t;

    typedef struct {
        logic [6:0] op;
        int         n;
        int         st [8];
        bit         rdy [8];
    } vec_t;

    typedef struct packed {
        logic [5:0] st;
        logic       rdy;
    } cyc_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    cyc_t q[$];
    bit   term;

    // Expected controls for a state code, straight from the state table.
    function automatic ctrl_t exp_ctrl(input logic [5:0] st, input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            6'd0: begin
                c.mrd = 1'b1;
                if (rdy) begin c.irw = 1'b1; c.pcw = 1'b1; c.srcb = 3'd1; end
            end
            6'd1:  begin c.srca = 2'd2; c.srcb = 3'd2; end
            6'd2:  begin c.srca = 2'd1; c.srcb = 3'd2; end
            6'd3:  begin c.iord = 1'b1; c.mrd = 1'b1; end
            6'd4:  begin c.regw = 1'b1; c.m2r = 2'd1; end
            6'd5:  begin c.iord = 1'b1; c.mwr = 1'b1; end
            6'd6:  begin c.srca = 2'd1; c.srcb = 3'd0; c.aluop = 2'd2; end
            6'd7:  begin c.srca = 2'd1; c.srcb = 3'd2; c.aluop = 2'd2; end
            6'd8:  begin c.srcb = 3'd2; c.aluop = 2'd3; end
            6'd9:  begin c.regw = 1'b1; end
            6'd10: begin c.srca = 2'd1; c.aluop = 2'd1; c.pcwc = 1'b1; c.pcsrc = 2'd1; end
            6'd11: begin c.regw = 1'b1; c.m2r = 2'd2; c.pcw = 1'b1; c.pcsrc = 2'd1; end
            6'd12: begin
                c.srca = 2'd1; c.srcb = 3'd2; c.pcsrc = 2'd3;
                c.pcw = 1'b1; c.regw = 1'b1; c.m2r = 2'd2;
            end
            6'd62: begin c.halt = 1'b1; end
            6'd63: begin c.halt = 1'b1; c.buserr = 1'b1; end
            default: c = '1;
        endcase
        return c;
    endfunction

    function automatic ctrl_t act_ctrl();
        ctrl_t c;
        c.irw    = bus.oIRWrite;
        c.pcw    = bus.oPCWrite;
        c.pcwc   = bus.oPCWriteCond;
        c.pcsrc  = bus.oPCSource;
        c.iord   = bus.oIorD;
        c.mrd    = bus.oMemRead;
        c.mwr    = bus.oMemWrite;
        c.m2r    = bus.oMemtoReg;
        c.regw   = bus.oRegWrite;
        c.srca   = bus.oALUSrcA;
        c.srcb   = bus.oALUSrcB;
        c.aluop  = bus.oALUOp;
        c.halt   = bus.oHalt;
        c.buserr = bus.oBusErr;
        return c;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: drive ready, check state and controls mid-cycle.
    task automatic step(input logic rdy, input logic [5:0] exp_st, input string tag);
        bus.iMemReady = rdy;
        #1;
        check_val({tag, " state"}, 32'(bus.oState), 32'(exp_st));
        check_val({tag, " ctrl"}, 32'(act_ctrl()), 32'(exp_ctrl(exp_st, rdy)));
        @(posedge iCLK);
        #1;
    endtask

    // Asynchronous reset pulse with checks taken before any clock edge.
    task automatic reset_pulse(input string tag);
        ctrl_t e;
        bus.iMemReady = 1'b1;
        iRST = 1'b0;
        #1;
        e = exp_ctrl(6'd0, 1'b1);
        e.irw = 1'b0;
        e.pcw = 1'b0;
        check_val({tag, " rst state"}, 32'(bus.oState), 32'd0);
        check_val({tag, " rst ctrl"}, 32'(act_ctrl()), 32'(e));
        #1;
        iRST = 1'b1;
    endtask

    // ---------------- reference model: expected cycle sequence ----------
    task automatic push(input int st, input logic rdy);
        cyc_t c;
        c.st  = 6'(st);
        c.rdy = rdy;
        q.push_back(c);
    endtask

    task automatic push_mem(input int st, input int waits);
        if (waits >= LIMIT) begin
            repeat (LIMIT) push(st, 1'b0);
            repeat (3) push(63, 1'($urandom_range(0, 1)));
            term = 1'b1;
        end else begin
            repeat (waits) push(st, 1'b0);
            push(st, 1'b1);
        end
    endtask

    function automatic int rand_waits();
        int r;
        r = int'($urandom_range(0, 31));
        return (r < 24) ? 0 : r - 23;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic build(input logic [6:0] op);
        q.delete();
        term = 1'b0;
        push_mem(0, rand_waits());
        if (!term) begin
            push(1, rnd());
            case (op)
                OP_LOAD: begin
                    push(2, rnd());
                    push_mem(3, rand_waits());
                    if (!term) push(4, rnd());
                end
                OP_STORE: begin
                    push(2, rnd());
                    push_mem(5, rand_waits());
                end
                OP_RTYPE:  begin push(6, rnd()); push(9, rnd()); end
                OP_ITYPE:  begin push(7, rnd()); push(9, rnd()); end
                OP_LUI:    begin push(8, rnd()); push(9, rnd()); end
                OP_AUIPC:  push(9, rnd());
                OP_BRANCH: push(10, rnd());
                OP_JAL:    push(11, rnd());
                OP_JALR:   push(12, rnd());
                default: begin
                    repeat (3) push(62, rnd());
                    term = 1'b1;
                end
            endcase
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE || op == OP_ITYPE ||
               op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_LUI ||
               op == OP_AUIPC;
    endfunction

    vec_t vecs [10];

    initial begin
        logic [6:0] legal_ops [9];
        logic [6:0] op;

        vecs[0] = '{op: OP_RTYPE,  n: 4, st: '{0, 1, 6, 9, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[1] = '{op: OP_ITYPE,  n: 4, st: '{0, 1, 7, 9, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[2] = '{op: OP_LUI,    n: 4, st: '{0, 1, 8, 9, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[3] = '{op: OP_AUIPC,  n: 3, st: '{0, 1, 9, 0, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[4] = '{op: OP_LOAD,   n: 8, st: '{0, 1, 2, 3, 3, 3, 3, 4}, rdy: '{1, 1, 1, 0, 0, 0, 1, 1}};
        vecs[5] = '{op: OP_STORE,  n: 4, st: '{0, 1, 2, 5, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[6] = '{op: OP_BRANCH, n: 3, st: '{0, 1, 10, 0, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[7] = '{op: OP_JAL,    n: 3, st: '{0, 1, 11, 0, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        vecs[8] = '{op: OP_JALR,   n: 3, st: '{0, 1, 12, 0, 0, 0, 0, 0}, rdy: '{1, 1, 1, 1, 1, 1, 1, 1}};
        // ready arrives on the limit cycle of FETCH: completion wins
        vecs[9] = '{op: OP_RTYPE,  n: 7, st: '{0, 0, 0, 0, 1, 6, 9, 0}, rdy: '{0, 0, 0, 1, 1, 1, 1, 1}};

        legal_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        bus.iOp       = 7'd0;
        bus.iMemReady = 1'b1;
        iRST          = 1'b0;
        @(posedge iCLK);
        #1;
        reset_pulse("init");

        // ---------------- directed vector table ----------------
        for (int v = 0; v < 10; v++) begin
            bus.iOp = vecs[v].op;
            for (int i = 0; i < vecs[v].n; i++)
                step(vecs[v].rdy[i], 6'(vecs[v].st[i]), $sformatf("vec%0d c%0d", v, i));
            $display("vec %0d op=%b cycles=%0d", v, vecs[v].op, vecs[v].n);
        end

        // ---------------- illegal opcode: sticky halt ----------------
        bus.iOp = 7'b1111111;
        step(1'b1, 6'd0, "ill");
        step(1'b1, 6'd1, "ill");
        for (int i = 0; i < 22; i++)
            step(rnd(), 6'd62, $sformatf("ill hold%0d", i));
        reset_pulse("ill");
        $display("seq illegal op=1111111 halted then reset");

        // ---------------- fetch timeout -> bus error ----------------
        bus.iOp = OP_RTYPE;
        for (int i = 0; i < LIMIT; i++)
            step(1'b0, 6'd0, $sformatf("to wait%0d", i));
        for (int i = 0; i < 3; i++)
            step(rnd(), 6'd63, $sformatf("to hold%0d", i));
        reset_pulse("to");
        $display("seq fetch timeout -> buserr then reset");

        // ---------------- reset during a held store ----------------
        bus.iOp = OP_STORE;
        step(1'b1, 6'd0, "strst");
        step(1'b1, 6'd1, "strst");
        step(1'b1, 6'd2, "strst");
        step(1'b0, 6'd5, "strst");
        bus.iMemReady = 1'b0;
        #1;
        check_val("strst memwrite before rst", 32'(bus.oMemWrite), 32'd1);
        reset_pulse("strst");
        $display("seq reset mid-MEMWRITE");

        // ---------------- randomized instructions ----------------
        for (int k = 0; k < 200; k++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 18) begin
                op = legal_ops[r % 9];
            end else begin
                op = 7'($urandom_range(0, 127));
                while (is_legal(op)) op = 7'($urandom_range(0, 127));
            end
            build(op);
            bus.iOp = op;
            $display("rand %0d op=%b cycles=%0d term=%0d", k, op, q.size(), term);
            foreach (q[i])
                step(q[i].rdy, q[i].st, $sformatf("rand%0d c%0d", k, i));
            if (term) reset_pulse($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
